// File: rtl/gcd_pkg.sv
// Shared types for the binary (Stein) GCD engine: FSM states, datapath
// operation codes and the worst-case latency helper.
package gcd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD_A,
        LD_B,
        CHECK,
        STRIP,
        ODDA,
        LOOP,
        FIN,
        DONE
    } gcd_state_t;

    // One operation per cycle is applied to the a/b/k registers.
    typedef enum logic [2:0] {
        DP_HOLD,
        DP_LOAD_A,
        DP_LOAD_B,
        DP_STRIP,
        DP_SHR_A,
        DP_SHR_B,
        DP_SWAP_SUB,
        DP_SUB_B
    } dp_op_t;

    function automatic int LAT_MAX(input int w);
        return 3 * w + 6;
    endfunction

endpackage

// File: rtl/gcd_stein_dp.sv
// Stein GCD datapath: operand registers a/b, shared power-of-two counter k,
// subtract/compare logic and a log-depth left shifter producing a << k.
module gcd_stein_dp
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  dp_op_t           op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic             a_zero,
    output logic             b_zero,
    output logic             a_odd,
    output logic             b_odd,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;
    logic [WIDTH-1:0] stage [KW+1];

    assign diff_ab = a_reg - b_reg;
    assign diff_ba = b_reg - a_reg;

    assign a_val  = a_reg;
    assign b_val  = b_reg;
    assign a_zero = (a_reg == '0);
    assign b_zero = (b_reg == '0);
    assign a_odd  = a_reg[0];
    assign b_odd  = b_reg[0];
    assign a_gt_b = (a_reg > b_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            k_reg <= '0;
        end else begin
            case (op)
                // Every (re)start passes through LD_A, so k is cleared here.
                DP_LOAD_A: begin
                    a_reg <= din;
                    k_reg <= '0;
                end
                DP_LOAD_B: b_reg <= din;
                DP_STRIP: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    k_reg <= k_reg + KW'(1);
                end
                DP_SHR_A:    a_reg <= a_reg >> 1;
                DP_SHR_B:    b_reg <= b_reg >> 1;
                DP_SWAP_SUB: begin
                    a_reg <= b_reg;
                    b_reg <= diff_ab;
                end
                DP_SUB_B:    b_reg <= diff_ba;
                default: begin
                    a_reg <= a_reg;
                    b_reg <= b_reg;
                    k_reg <= k_reg;
                end
            endcase
        end
    end

    // Stage gi shifts by 2**gi when bit gi of k is set.
    assign stage[0] = a_reg;
    for (genvar gi = 0; gi < KW; gi++) begin : g_shift
        assign stage[gi+1] = k_reg[gi] ? (stage[gi] << (2 ** gi)) : stage[gi];
    end
    assign shifted = stage[KW];

endmodule

// File: rtl/gcd_stein_core.sv
// Binary GCD engine with serial operand load, busy/done handshake,
// zero-operand detection and restart on any load pulse.
module gcd_stein_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] gcd_rslt,
    output logic             done,
    output logic             busy,
    output logic             zero_err
);

    localparam int KW = $clog2(WIDTH + 1);

    gcd_state_t       state_reg;
    gcd_state_t       state_next;
    dp_op_t           dp_op;
    logic [WIDTH-1:0] rslt_reg;
    logic             done_reg;
    logic             busy_reg;
    logic             zero_err_reg;

    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic [WIDTH-1:0] shifted;
    logic             a_zero;
    logic             b_zero;
    logic             a_odd;
    logic             b_odd;
    logic             a_gt_b;
    logic             check_hit;

    gcd_stein_dp #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .op      (dp_op),
        .din     (din),
        .a_val   (a_val),
        .b_val   (b_val),
        .a_zero  (a_zero),
        .b_zero  (b_zero),
        .a_odd   (a_odd),
        .b_odd   (b_odd),
        .a_gt_b  (a_gt_b),
        .shifted (shifted)
    );

    assign check_hit = (state_reg == CHECK) && (a_zero || b_zero);

    always_comb begin
        state_next = state_reg;
        dp_op      = DP_HOLD;
        // A load pulse overrides whatever step is in progress.
        if (load) begin
            state_next = LD_A;
        end else begin
            case (state_reg)
                LD_A: begin
                    dp_op      = DP_LOAD_A;
                    state_next = LD_B;
                end
                LD_B: begin
                    dp_op      = DP_LOAD_B;
                    state_next = CHECK;
                end
                CHECK:   state_next = (a_zero || b_zero) ? DONE : STRIP;
                STRIP: begin
                    if (!a_odd && !b_odd) dp_op = DP_STRIP;
                    else                  state_next = ODDA;
                end
                ODDA: begin
                    if (!a_odd) dp_op = DP_SHR_A;
                    else        state_next = LOOP;
                end
                LOOP: begin
                    if (b_zero)      state_next = FIN;
                    else if (!b_odd) dp_op = DP_SHR_B;
                    else if (a_gt_b) dp_op = DP_SWAP_SUB;
                    else             dp_op = DP_SUB_B;
                end
                FIN:     state_next = DONE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rslt_reg     <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            zero_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                done_reg     <= 1'b0;
                busy_reg     <= 1'b1;
                zero_err_reg <= 1'b0;
            end else if (check_hit) begin
                // With one operand zero the other is the answer; both zero gives 0.
                rslt_reg     <= a_zero ? b_val : a_val;
                zero_err_reg <= a_zero && b_zero;
                done_reg     <= 1'b1;
                busy_reg     <= 1'b0;
            end else if (state_reg == FIN) begin
                rslt_reg <= shifted;
                done_reg <= 1'b1;
                busy_reg <= 1'b0;
            end
        end
    end

    assign gcd_rslt = rslt_reg;
    assign done     = done_reg;
    assign busy     = busy_reg;
    assign zero_err = zero_err_reg;

endmodule

// File: tb/tb_gcd_stein_core.sv
// Bench for gcd_stein_core at WIDTH=8 and WIDTH=16 against a Euclid reference.
module tb_gcd_stein_core;
    import gcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load8, load16;
    logic [7:0]  din8;
    logic [15:0] din16;
    logic [7:0]  rslt8;
    logic [15:0] rslt16;
    logic        done8, done16, busy8, busy16, zerr8, zerr16;

    logic        sel16;
    logic [15:0] cur_rslt;
    logic        cur_done, cur_busy, cur_zerr;

    int cyc_cnt = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    gcd_stein_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load(load8), .din(din8),
        .gcd_rslt(rslt8), .done(done8), .busy(busy8), .zero_err(zerr8)
    );

    gcd_stein_core #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .load(load16), .din(din16),
        .gcd_rslt(rslt16), .done(done16), .busy(busy16), .zero_err(zerr16)
    );

    always_comb begin
        cur_rslt = sel16 ? rslt16 : {8'd0, rslt8};
        cur_done = sel16 ? done16 : done8;
        cur_busy = sel16 ? busy16 : busy8;
        cur_zerr = sel16 ? zerr16 : zerr8;
    end

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 16'(x);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic ld, input logic [15:0] d);
        if (sel16) begin
            load16 = ld;
            din16  = d;
        end else begin
            load8 = ld;
            din8  = d[7:0];
        end
    endtask

    task automatic start_op(input logic w16, input logic [15:0] a, input logic [15:0] b,
                            output int t0);
        @(negedge clk);
        sel16 = w16;
        set_in(1'b1, 16'($urandom));
        @(negedge clk);
        t0 = cyc_cnt;
        set_in(1'b0, a);
        @(negedge clk);
        set_in(1'b0, b);
    endtask

    task automatic wait_done(input int t0, input int bound, output int lat,
                             output bit timed_out, output bit busy_bad);
        bit fin = 0;
        timed_out = 0;
        busy_bad  = 0;
        while (!fin) begin
            @(negedge clk);
            set_in(1'b0, 16'($urandom));
            if (cur_done) begin
                fin = 1;
            end else begin
                if (!cur_busy) busy_bad = 1;
                if (cyc_cnt - t0 > bound) begin
                    timed_out = 1;
                    fin = 1;
                end
            end
        end
        lat = cyc_cnt - t0;
    endtask

    task automatic finish_checks(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input int lat, input int max_lat,
                                 input bit timed_out, input bit busy_bad);
        logic [15:0] exp = ref_gcd(a, b);
        check_val({tag, "_timeout"}, 32'(timed_out), 32'd0);
        check_val({tag, "_rslt"}, 32'(cur_rslt), 32'(exp));
        check_val({tag, "_zero_err"}, 32'(cur_zerr), 32'((a == 0) && (b == 0)));
        check_val({tag, "_busy_at_done"}, 32'(cur_busy), 32'd0);
        check_val({tag, "_busy_while_running"}, 32'(busy_bad), 32'd0);
        if (max_lat > 0) check_val({tag, "_latency_ok"}, 32'(lat <= max_lat), 32'd1);
        $display("[TB] %s w=%0d gcd(%0d,%0d) got=%0d exp=%0d zero_err=%0d lat=%0d",
                 tag, sel16 ? 16 : 8, a, b, cur_rslt, exp, cur_zerr, lat);
    endtask

    task automatic run_case(input string tag, input logic w16, input logic [15:0] a,
                            input logic [15:0] b, input int max_lat);
        int t0, lat;
        bit to, bb;
        start_op(w16, a, b, t0);
        wait_done(t0, w16 ? 8 * 16 + 16 : 8 * 8 + 16, lat, to, bb);
        finish_checks(tag, a, b, lat, max_lat, to, bb);
    endtask

    initial begin
        int t0, lat;
        bit to, bb, stale;
        logic [15:0] ra, rb, mask;

        rst = 1'b1;
        sel16 = 1'b0;
        load8 = 1'b0; load16 = 1'b0;
        din8 = '0; din16 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset_rslt8", 32'(rslt8), 32'd0);
        check_val("reset_done8", 32'(done8), 32'd0);
        check_val("reset_busy8", 32'(busy8), 32'd0);
        check_val("reset_zerr8", 32'(zerr8), 32'd0);
        check_val("reset_rslt16", 32'(rslt16), 32'd0);
        check_val("reset_done16", 32'(done16), 32'd0);

        run_case("t1_27_18", 1'b0, 16'd27, 16'd18, 30);
        run_case("t2_48_18", 1'b0, 16'd48, 16'd18, LAT_MAX(8));
        run_case("t2_17_13", 1'b0, 16'd17, 16'd13, LAT_MAX(8));
        run_case("t3_0_35", 1'b0, 16'd0, 16'd35, 7);
        run_case("t3_0_0", 1'b0, 16'd0, 16'd0, LAT_MAX(8));
        run_case("t3_35_0", 1'b0, 16'd35, 16'd0, 7);
        run_case("t4_65535_255", 1'b1, 16'd65535, 16'd255, LAT_MAX(16));
        run_case("t4_49152_32768", 1'b1, 16'd49152, 16'd32768, LAT_MAX(16));
        run_case("edge_255_255", 1'b0, 16'd255, 16'd255, LAT_MAX(8));
        run_case("edge_128_64", 1'b0, 16'd128, 16'd64, LAT_MAX(8));

        // Abort: restart three cycles into LOOP of 27/18; 9 must never appear.
        start_op(1'b0, 16'd27, 16'd18, t0);
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            set_in(1'b0, 16'($urandom));
            if (cur_done) stale = 1;
        end
        start_op(1'b0, 16'd12, 16'd8, t0);
        wait_done(t0, 8 * 8 + 16, lat, to, bb);
        check_val("t5_abort_no_early_done", 32'(stale), 32'd0);
        finish_checks("t5_abort_12_8", 16'd12, 16'd8, lat, LAT_MAX(8), to, bb);

        // Back-to-back load pulses: the second one defines the operands.
        @(negedge clk);
        sel16 = 1'b0;
        set_in(1'b1, 16'd0);
        @(negedge clk);
        set_in(1'b1, 16'd99);
        @(negedge clk);
        t0 = cyc_cnt;
        set_in(1'b0, 16'd21);
        @(negedge clk);
        set_in(1'b0, 16'd14);
        wait_done(t0, 8 * 8 + 16, lat, to, bb);
        finish_checks("last_load_wins_21_14", 16'd21, 16'd14, lat, 0, to, bb);

        // Reset in the middle of LOOP.
        start_op(1'b0, 16'd27, 16'd18, t0);
        repeat (5) begin
            @(negedge clk);
            set_in(1'b0, 16'($urandom));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t6_rst_rslt", 32'(rslt8), 32'd0);
        check_val("t6_rst_done", 32'(done8), 32'd0);
        check_val("t6_rst_busy", 32'(busy8), 32'd0);
        check_val("t6_rst_zerr", 32'(zerr8), 32'd0);
        check_val("t6_rst_state", 32'(dut8.state_reg), 32'(IDLE));
        run_case("t6_100_75", 1'b0, 16'd100, 16'd75, LAT_MAX(8));

        for (int i = 0; i < 60; i++) begin
            mask = (i % 2 == 1) ? 16'hFFFF : 16'h00FF;
            ra = 16'($urandom) & mask;
            rb = 16'($urandom) & mask;
            if ($urandom_range(0, 9) == 0) ra = '0;
            if ($urandom_range(0, 9) == 0) rb = '0;
            if ($urandom_range(0, 3) == 0) begin
                ra = (ra << $urandom_range(1, 4)) & mask;
                rb = (rb << $urandom_range(1, 4)) & mask;
            end
            run_case("rand", (i % 2 == 1), ra, rb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
